// File: rtl/pong_pkg.sv
// Shared constants and encodings for the PONG game-state controller.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } game_state_e;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_e;

  localparam int unsigned SCREEN_W_DEF    = 800;
  localparam int unsigned SCREEN_H_DEF    = 600;
  localparam int unsigned BALL_SIZE_DEF   = 10;
  localparam int unsigned PADDLE_X_DEF    = 20;
  localparam int unsigned PADDLE_W_DEF    = 10;
  localparam int unsigned PADDLE_H_DEF    = 100;
  localparam int unsigned BALL_SPEED_DEF  = 4;
  localparam int unsigned SERVE_DELAY_DEF = 60;
  localparam int unsigned START_LIVES_DEF = 3;

endpackage

// File: rtl/pong_edge_det.sv
// One-flop delay of a level input plus a single-cycle rising-edge pulse.
module pong_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic d_q, d_d;

  always_comb d_d = din;

  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d_d;
  end

  assign pulse = din & ~d_q;

endmodule

// File: rtl/pong_ball_ctl.sv
// PONG game-state controller: serve/play/miss/over sequencing, ball motion,
// wall and paddle collisions, score and lives; updates once per frame.
module pong_ball_ctl
  import pong_pkg::*;
#(
  parameter int unsigned SCREEN_W    = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H    = SCREEN_H_DEF,
  parameter int unsigned BALL_SIZE   = BALL_SIZE_DEF,
  parameter int unsigned PADDLE_X    = PADDLE_X_DEF,
  parameter int unsigned PADDLE_W    = PADDLE_W_DEF,
  parameter int unsigned PADDLE_H    = PADDLE_H_DEF,
  parameter int unsigned BALL_SPEED  = BALL_SPEED_DEF,
  parameter int unsigned SERVE_DELAY = SERVE_DELAY_DEF,
  parameter int unsigned START_LIVES = START_LIVES_DEF
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vblnk_in,
  input  logic        start,
  input  logic [11:0] paddle_ypos,
  output logic [11:0] ball_xpos,
  output logic [11:0] ball_ypos,
  output logic        ball_visible,
  output logic [7:0]  score,
  output logic [1:0]  lives,
  output logic [1:0]  game_state
);

  localparam int CNT_W = (SERVE_DELAY < 2) ? 1 : $clog2(SERVE_DELAY + 1);

  localparam logic [11:0] X_CTR  = 12'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [11:0] Y_CTR  = 12'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [11:0] X_MAX  = 12'(SCREEN_W - BALL_SIZE);
  localparam logic [11:0] Y_MAX  = 12'(SCREEN_H - BALL_SIZE);
  localparam logic [11:0] PF12   = 12'(PADDLE_X + PADDLE_W);
  localparam logic [12:0] W13    = 13'(SCREEN_W);
  localparam logic [12:0] H13    = 13'(SCREEN_H);
  localparam logic [12:0] B13    = 13'(BALL_SIZE);
  localparam logic [12:0] S13    = 13'(BALL_SPEED);
  localparam logic [12:0] PF13   = 13'(PADDLE_X + PADDLE_W);
  localparam logic [12:0] PH13   = 13'(PADDLE_H);

  logic tick, start_p;

  pong_edge_det u_vblnk_edge (.clk(pclk), .rst(rst), .din(vblnk_in), .pulse(tick));
  pong_edge_det u_start_edge (.clk(pclk), .rst(rst), .din(start),    .pulse(start_p));

  game_state_e      state_q, state_d;
  dir_e             dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [11:0]      x_q, x_d, y_q, y_d;
  logic [7:0]       score_q, score_d;
  logic [1:0]       lives_q, lives_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vis_q, vis_d;

  // Candidate motion for this tick; 13-bit so edge sums never wrap.
  logic [12:0] x_w, y_w, pad_w;
  logic [11:0] x_mv, y_mv;
  dir_e        xdir_mv, ydir_mv;
  logic        hit, miss;

  always_comb begin
    x_w     = {1'b0, x_q};
    y_w     = {1'b0, y_q};
    pad_w   = {1'b0, paddle_ypos};
    x_mv    = x_q;
    y_mv    = y_q;
    xdir_mv = dir_x_q;
    ydir_mv = dir_y_q;
    hit     = 1'b0;
    miss    = 1'b0;

    if (dir_y_q == DIR_POS) begin
      if (y_w + B13 + S13 >= H13) begin
        y_mv    = Y_MAX;
        ydir_mv = DIR_NEG;
      end else begin
        y_mv = 12'(y_w + S13);
      end
    end else if (y_w <= S13) begin
      y_mv    = '0;
      ydir_mv = DIR_POS;
    end else begin
      y_mv = 12'(y_w - S13);
    end

    if (dir_x_q == DIR_POS) begin
      if (x_w + B13 + S13 >= W13) begin
        x_mv    = X_MAX;
        xdir_mv = DIR_NEG;
      end else begin
        x_mv = 12'(x_w + S13);
      end
    end else if (x_w >= PF13 && x_w <= PF13 + S13 &&
                 y_w + B13 > pad_w && y_w < pad_w + PH13) begin
      hit     = 1'b1;
      x_mv    = PF12;
      xdir_mv = DIR_POS;
    end else if (x_w <= S13) begin
      miss = 1'b1;
    end else begin
      x_mv = 12'(x_w - S13);
    end
  end

  always_comb begin
    state_d = state_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    x_d     = x_q;
    y_d     = y_q;
    score_d = score_q;
    lives_d = lives_q;
    cnt_d   = cnt_q;
    vis_d   = vis_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_p) begin
          state_d = ST_SERVE;
          cnt_d   = CNT_W'(SERVE_DELAY);
          vis_d   = 1'b1;
        end
      end
      ST_SERVE: begin
        if (tick) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (tick) begin
          if (miss) begin
            // The y step computed alongside a miss is dropped with the serve reset.
            x_d     = X_CTR;
            y_d     = Y_CTR;
            dir_x_d = DIR_POS;
            dir_y_d = DIR_POS;
            if (lives_q == 2'd1) begin
              lives_d = 2'd0;
              state_d = ST_OVER;
              vis_d   = 1'b0;
            end else begin
              lives_d = lives_q - 2'd1;
              state_d = ST_SERVE;
              cnt_d   = CNT_W'(SERVE_DELAY);
            end
          end else begin
            x_d     = x_mv;
            y_d     = y_mv;
            dir_x_d = xdir_mv;
            dir_y_d = ydir_mv;
            if (hit && score_q != 8'hFF) score_d = score_q + 8'd1;
          end
        end
      end
      ST_OVER: begin
        if (start_p) begin
          state_d = ST_SERVE;
          cnt_d   = CNT_W'(SERVE_DELAY);
          score_d = '0;
          lives_d = 2'(START_LIVES);
          vis_d   = 1'b1;
          dir_x_d = DIR_POS;
          dir_y_d = DIR_POS;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dir_x_q <= DIR_POS;
      dir_y_q <= DIR_POS;
      x_q     <= X_CTR;
      y_q     <= Y_CTR;
      score_q <= '0;
      lives_q <= 2'(START_LIVES);
      cnt_q   <= '0;
      vis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      x_q     <= x_d;
      y_q     <= y_d;
      score_q <= score_d;
      lives_q <= lives_d;
      cnt_q   <= cnt_d;
      vis_q   <= vis_d;
    end
  end

  assign ball_xpos    = x_q;
  assign ball_ypos    = y_q;
  assign ball_visible = vis_q;
  assign score        = score_q;
  assign lives        = lives_q;
  assign game_state   = state_q;

endmodule

// File: tb/tb_pong_ball_ctl.sv
// Bench for pong_ball_ctl: directed game scenarios plus random frames, all
// cycles compared against a frame-level behavioural game model.
module tb_pong_ball_ctl;

  logic        pclk = 1'b0;
  logic        rst, vblnk_in, start;
  logic [11:0] paddle_ypos;
  logic [11:0] ball_xpos, ball_ypos;
  logic        ball_visible;
  logic [7:0]  score;
  logic [1:0]  lives, game_state;

  int n_chk = 0;
  int n_err = 0;

  always #5 pclk = ~pclk;

  pong_ball_ctl dut (
    .pclk(pclk), .rst(rst), .vblnk_in(vblnk_in), .start(start),
    .paddle_ypos(paddle_ypos), .ball_xpos(ball_xpos), .ball_ypos(ball_ypos),
    .ball_visible(ball_visible), .score(score), .lives(lives),
    .game_state(game_state)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Game model: positions as ints, directions as +1/-1, states as 0..3.
  int mx, my, mdx, mdy, mscore, mlives, mgs, mcnt, mvis;
  int m_ticks = 0;
  bit m_vprev = 0, m_sprev = 0;
  bit cmp_en = 0;

  always @(posedge pclk) begin : model
    bit tk, sp, mis;
    int nx, ny, ndx, ndy, pad;
    tk = vblnk_in && !m_vprev;
    sp = start && !m_sprev;
    m_vprev = vblnk_in;
    m_sprev = start;
    if (tk) m_ticks++;
    if (rst) begin
      m_vprev = 0; m_sprev = 0;
      mx = 395; my = 295; mdx = 1; mdy = 1;
      mscore = 0; mlives = 3; mgs = 0; mcnt = 0; mvis = 0;
    end else begin
      case (mgs)
        0: if (sp) begin mgs = 1; mcnt = 60; mvis = 1; end
        1: if (tk) begin mcnt--; if (mcnt == 0) mgs = 2; end
        2: if (tk) begin
          pad = int'(paddle_ypos);
          ndx = mdx; ndy = mdy; mis = 0; nx = mx;
          if (mdy > 0) begin
            if (my + 14 >= 600) begin ny = 590; ndy = -1; end else ny = my + 4;
          end else begin
            if (my <= 4) begin ny = 0; ndy = 1; end else ny = my - 4;
          end
          if (mdx > 0) begin
            if (mx + 14 >= 800) begin nx = 790; ndx = -1; end else nx = mx + 4;
          end else if (mx >= 30 && mx <= 34 && my + 10 > pad && my < pad + 100) begin
            nx = 30; ndx = 1;
            if (mscore < 255) mscore++;
          end else if (mx <= 4) mis = 1;
          else nx = mx - 4;
          if (mis) begin
            mx = 395; my = 295; mdx = 1; mdy = 1;
            if (mlives == 1) begin mlives = 0; mgs = 3; mvis = 0; end
            else begin mlives--; mgs = 1; mcnt = 60; end
          end else begin
            mx = nx; my = ny; mdx = ndx; mdy = ndy;
          end
        end
        default: if (sp) begin
          mgs = 1; mcnt = 60; mvis = 1; mscore = 0; mlives = 3; mdx = 1; mdy = 1;
        end
      endcase
    end
  end

  always @(negedge pclk) begin
    if (cmp_en) begin
      chk("ball_xpos", int'(ball_xpos), mx);
      chk("ball_ypos", int'(ball_ypos), my);
      chk("ball_visible", int'(ball_visible), mvis);
      chk("score", int'(score), mscore);
      chk("lives", int'(lives), mlives);
      chk("game_state", int'(game_state), mgs);
    end
  end

  // One frame: vblank high for hi cycles, low for lo cycles; ends on a negedge
  // after the tick's update is visible.
  task automatic frame(input int hi, input int lo);
    @(negedge pclk);
    vblnk_in = 1'b1;
    repeat (hi) @(negedge pclk);
    vblnk_in = 1'b0;
    repeat (lo) @(negedge pclk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, int'(game_state), 0);
    chk({tag, "_x"}, int'(ball_xpos), 395);
    chk({tag, "_y"}, int'(ball_ypos), 295);
    chk({tag, "_vis"}, int'(ball_visible), 0);
    chk({tag, "_lives"}, int'(lives), 3);
    chk({tag, "_score"}, int'(score), 0);
  endtask

  initial begin
    int t0;
    rst = 1'b1; vblnk_in = 1'b0; start = 1'b0; paddle_ypos = 12'd0;
    repeat (3) @(negedge pclk);
    cmp_en = 1'b1;
    chk_reset_vals("reset");
    rst = 1'b0;

    // Long vblank yields a single tick; IDLE ignores it.
    t0 = m_ticks;
    vblnk_in = 1'b1;
    repeat (1000) @(negedge pclk);
    vblnk_in = 1'b0;
    @(negedge pclk);
    chk("long_vblank_ticks", m_ticks - t0, 1);
    chk_reset_vals("idle_after_vblank");

    // Start held for 5 cycles: one serve.
    start = 1'b1;
    repeat (5) @(negedge pclk);
    start = 1'b0;
    chk("serve_state", int'(game_state), 1);
    chk("serve_vis", int'(ball_visible), 1);
    paddle_ypos = 12'd4095;
    repeat (59) frame(2, 2);
    chk("serve59_state", int'(game_state), 1);
    chk("serve59_x", int'(ball_xpos), 395);
    frame(2, 2);
    chk("play_entry_state", int'(game_state), 2);
    chk("play_entry_y", int'(ball_ypos), 295);
    frame(2, 2);
    chk("play1_x", int'(ball_xpos), 399);
    chk("play1_y", int'(ball_ypos), 299);
    repeat (73) frame(1, 1);
    chk("bottom_bounce_y", int'(ball_ypos), 590);
    chk("model_bottom_y", my, 590);
    chk("model_dir_up", mdy, -1);
    repeat (25) frame(1, 1);
    chk("right_bounce_x", int'(ball_xpos), 790);
    chk("model_dir_left", mdx, -1);
    for (int i = 0; i < 300 && lives == 2'd3; i++) frame(1, 1);
    chk("miss_lives", int'(lives), 2);
    chk("miss_state", int'(game_state), 1);
    chk("miss_x", int'(ball_xpos), 395);
    chk("miss_y", int'(ball_ypos), 295);

    // Paddle tracks the ball: first left-moving window tick is a hit.
    for (int i = 0; i < 800 && score == 8'd0; i++) begin
      paddle_ypos = (ball_ypos >= 12'd45) ? ball_ypos - 12'd45 : 12'd0;
      frame(1, 1);
    end
    chk("hit_x", int'(ball_xpos), 30);
    chk("hit_score", int'(score), 1);
    chk("hit_lives", int'(lives), 2);
    chk("hit_state", int'(game_state), 2);
    frame(1, 1);
    chk("after_hit_x", int'(ball_xpos), 34);

    // Remaining lives lost: game over, then restart.
    paddle_ypos = 12'd4095;
    for (int i = 0; i < 2000 && game_state != 2'd3; i++) frame(1, 1);
    chk("over_state", int'(game_state), 3);
    chk("over_lives", int'(lives), 0);
    chk("over_vis", int'(ball_visible), 0);
    chk("over_score_kept", int'(score), 1);
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
    @(negedge pclk);
    chk("restart_state", int'(game_state), 1);
    chk("restart_lives", int'(lives), 3);
    chk("restart_score", int'(score), 0);
    chk("restart_vis", int'(ball_visible), 1);

    // Reset coincident with a tick mid-play.
    for (int i = 0; i < 80 && game_state != 2'd2; i++) frame(1, 1);
    repeat (5) frame(1, 1);
    chk("pre_rst_x", int'(ball_xpos), 415);
    @(negedge pclk);
    rst = 1'b1;
    vblnk_in = 1'b1;
    @(negedge pclk);
    rst = 1'b0;
    chk_reset_vals("rst_on_tick");
    vblnk_in = 1'b0;
    @(negedge pclk);

    // Random frames, start toggles, paddle positions and rare resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) start = ~start;
      paddle_ypos = 12'($urandom_range(0, 700));
      if ($urandom_range(0, 399) == 0) begin
        @(negedge pclk);
        rst = 1'b1;
        @(negedge pclk);
        rst = 1'b0;
      end
      frame($urandom_range(1, 4), $urandom_range(1, 3));
    end

    @(negedge pclk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
